// File: rtl/sigma_out_collector.sv
// sigma_out_collector
// Serializes the per-lane results of the PE output stage into a single
// valid/ready result stream. Each cycle with any lane valid is a capture
// group; up to two groups are held in ping-pong banks and drained
// lowest-lane-first, one result per handshake.
//
// Ports
//   clk            : single clock, rising edge
//   rst            : asynchronous active-low reset
//   i_data_valid   : per-lane result valid (NUM_PES bits)
//   i_data_bus     : per-lane results, lane k at [k*OUT_DATA_TYPE +: OUT_DATA_TYPE]
//   o_valid        : a serialized result is presented
//   i_ready        : consumer accepts o_data this cycle
//   o_data         : current result (0 when o_valid is low)
//   o_lane         : source lane of o_data (0 when o_valid is low)
//   o_last         : o_data is the final result of its group (0 when o_valid is low)
//   o_busy         : both holding banks are occupied
//   o_overflow     : sticky, a capture group was dropped
//   i_clr_overflow : synchronous clear of o_overflow
module sigma_out_collector #(
    parameter int OUT_DATA_TYPE = 32,
    parameter int NUM_PES       = 32,
    parameter int LOG2_PES      = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PES-1:0]               i_data_valid,
    input  logic [NUM_PES*OUT_DATA_TYPE-1:0] i_data_bus,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [OUT_DATA_TYPE-1:0]         o_data,
    output logic [LOG2_PES-1:0]              o_lane,
    output logic                             o_last,
    output logic                             o_busy,
    output logic                             o_overflow,
    input  logic                             i_clr_overflow
);

    // Index of the lowest set bit; 0 for an all-zero mask.
    function automatic logic [LOG2_PES-1:0] lowest_index(input logic [NUM_PES-1:0] m);
        logic [LOG2_PES-1:0] idx;
        idx = '0;
        for (int i = NUM_PES - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = i[LOG2_PES-1:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [NUM_PES-1:0]               mask_r [2];
    logic [NUM_PES*OUT_DATA_TYPE-1:0] data_r [2];
    logic                             wr_ptr_r;
    logic                             rd_ptr_r;
    logic                             overflow_r;

    logic [NUM_PES-1:0]  rd_mask_s;
    logic [NUM_PES-1:0]  sel_onehot_s;
    logic [LOG2_PES-1:0] sel_lane_s;
    logic                rd_valid_s;
    logic                rd_last_s;
    logic                pop_s;
    logic                bank_done_s;
    logic                capture_s;
    logic                wr_free_s;
    logic                accept_s;
    logic                drop_s;

    // Read-side selection, handshake and write-bank availability.
    always_comb begin
        rd_mask_s    = mask_r[rd_ptr_r];
        // Isolate the lowest set bit (two's complement trick).
        sel_onehot_s = rd_mask_s & (~rd_mask_s + {{(NUM_PES-1){1'b0}}, 1'b1});
        sel_lane_s   = lowest_index(rd_mask_s);
        rd_valid_s   = |rd_mask_s;
        rd_last_s    = rd_valid_s && (rd_mask_s == sel_onehot_s);
        pop_s        = rd_valid_s && i_ready;
        bank_done_s  = pop_s && rd_last_s;
        capture_s    = |i_data_valid;
        // The write bank can only equal an occupied read bank when both banks
        // are full; it becomes reusable at this edge if its last result leaves.
        wr_free_s    = (mask_r[wr_ptr_r] == '0) ||
                       ((wr_ptr_r == rd_ptr_r) && bank_done_s);
        accept_s     = capture_s && wr_free_s;
        drop_s       = capture_s && !wr_free_s;
    end

    // Output presentation; everything is forced to zero when idle.
    always_comb begin
        o_valid = rd_valid_s;
        o_busy  = (mask_r[0] != '0) && (mask_r[1] != '0);
        if (rd_valid_s) begin
            o_data = data_r[rd_ptr_r][sel_lane_s*OUT_DATA_TYPE +: OUT_DATA_TYPE];
            o_lane = sel_lane_s;
            o_last = rd_last_s;
        end else begin
            o_data = '0;
            o_lane = '0;
            o_last = 1'b0;
        end
    end

    assign o_overflow = overflow_r;

    // Bank contents: a new capture overrides a same-cycle drain of that bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                mask_r[b] <= '0;
                data_r[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (accept_s && (wr_ptr_r == b[0])) begin
                    mask_r[b] <= i_data_valid;
                    data_r[b] <= i_data_bus;
                end else if (pop_s && (rd_ptr_r == b[0])) begin
                    mask_r[b] <= mask_r[b] & ~sel_onehot_s;
                    data_r[b] <= data_r[b];
                end else begin
                    mask_r[b] <= mask_r[b];
                    data_r[b] <= data_r[b];
                end
            end
        end
    end

    // Bank pointers and the sticky overflow flag (set beats clear).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= 1'b0;
            rd_ptr_r   <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            wr_ptr_r <= accept_s    ? ~wr_ptr_r : wr_ptr_r;
            rd_ptr_r <= bank_done_s ? ~rd_ptr_r : rd_ptr_r;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (i_clr_overflow) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

endmodule
